spgd_metric_diff: RTL
=====================

# spgd_metric_diff

Two-sided SPGD metric sequencer sitting directly downstream of the ADC averaging stage. Per iteration it drives the perturbation sign to +, holds the averager in reset through a settle window, releases it and captures the averaged metric J+. It then repeats for the − perturbation to capture J−, and emits the signed difference dJ = J+ − J− with a one-cycle valid pulse to the gradient/update stage.

## Interface
Parameters:
- ADC_WIDTH, 12, ADC sample width; averaged metric is ADC_WIDTH+1 bits signed
- SETTLE_CYCLES, 64, cycles the averager is held in reset after each sign change; legal range 1..65535
- TIMEOUT_CYCLES, 4096, cycle limit for averager completion; used only when the timeout feature is compiled in

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- START  in  1  one-cycle request to run one iteration; honoured only in IDLE
- AVG_DONE  in  1  averager completion flag, level
- AVG_DATA  in  ADC_WIDTH+1  averaged metric, signed
- AVG_RST  out  1  reset to averager; high holds it cleared
- PERT_SIGN  out  1  perturbation sign to actuator stage; 0 = +, 1 = −
- BUSY  out  1  high while an iteration is in progress
- J_PLUS  out  ADC_WIDTH+1  last captured J+, signed
- J_MINUS  out  ADC_WIDTH+1  last captured J−, signed
- DJ_OUT  out  ADC_WIDTH+2  J_PLUS − J_MINUS, signed
- DJ_VALID  out  1  one-cycle pulse; DJ_OUT is new
- ERR  out  1  one-cycle pulse on averager timeout

## Operation
- States: IDLE → SETTLE_P → AVG_P → SETTLE_M → AVG_M → OUTPUT → IDLE.
- IDLE: AVG_RST=1, PERT_SIGN=0, BUSY=0. START=1 → SETTLE_P.
- SETTLE_P / SETTLE_M:
  - PERT_SIGN = 0 / 1; AVG_RST=1.
  - Settle counter loaded to 0 on entry; state exits after exactly SETTLE_CYCLES cycles.
- AVG_P / AVG_M:
  - AVG_RST=0.
  - AVG_DONE is ignored in the first cycle of the state, to mask a stale flag while the averager leaves reset.
  - From the second cycle on, the first cycle with AVG_DONE=1 registers AVG_DATA into J_PLUS / J_MINUS and advances to SETTLE_M / OUTPUT.
- OUTPUT:
  - DJ_OUT ← sign-extend(J_PLUS) − sign-extend(J_MINUS) at ADC_WIDTH+2 bits. This cannot overflow; no saturation.
  - DJ_VALID=1 for this single cycle; AVG_RST=1, PERT_SIGN=0, then → IDLE.
- START outside IDLE is ignored, not queued.
- J_PLUS, J_MINUS and DJ_OUT hold their values between updates.
- RST at any cycle, including mid-iteration: synchronous return to IDLE; all outputs take their reset values the next cycle; a partial iteration is discarded.
- Reset values: AVG_RST=1, PERT_SIGN=0, BUSY=0, J_PLUS=0, J_MINUS=0, DJ_OUT=0, DJ_VALID=0, ERR=0.

## Timing
- START sampled high at edge t0 → SETTLE_P is active for cycles t0+1 … t0+SETTLE_CYCLES; BUSY=1 from t0+1.
- AVG_P is entered at t0+SETTLE_CYCLES+1. Its earliest valid capture is t0+SETTLE_CYCLES+2.
- Capture cycle tp (AVG_DONE seen) → SETTLE_M is active for tp+1 … tp+SETTLE_CYCLES. PERT_SIGN rises at tp+1.
- Capture cycle tm → OUTPUT at tm+1: DJ_VALID=1, DJ_OUT valid, BUSY=1. At tm+2: IDLE, BUSY=0; START accepted again from this cycle.
- PERT_SIGN and AVG_RST are registered outputs with no combinational path from inputs.

## Configuration
- Macro SPGD_METRIC_TIMEOUT_EN.
- Defined:
  - A timeout counter is cleared on entry to AVG_P/AVG_M.
  - If TIMEOUT_CYCLES cycles elapse in the state without a capture, ERR pulses for one cycle and the FSM returns to IDLE (AVG_RST=1, PERT_SIGN=0, BUSY=0 next cycle).
  - DJ_VALID does not pulse; J_PLUS, J_MINUS and DJ_OUT are unchanged unless that capture already happened in the aborted iteration.
- Undefined: no timeout counter; ERR tied 0; AVG states wait for AVG_DONE indefinitely.

## Test plan
- SETTLE_CYCLES=4, averager model asserts AVG_DONE 10 cycles after release, AVG_DATA=+300 during +, −200 during − → J_PLUS=300, J_MINUS=−200, DJ_OUT=500, DJ_VALID exactly 1 cycle, BUSY low next cycle.
- Extremes: J+=−4096, J−=4095 → DJ_OUT=−8191; J+=4095, J−=−4096 → DJ_OUT=8191; no wrap.
- AVG_DONE held high through the settle window and into the first AVG cycle, AVG_DATA=123 → no capture in the first AVG cycle; capture in the second cycle.
- START pulsed repeatedly while BUSY=1 → exactly one DJ_VALID; START at tm+2 starts a new iteration with SETTLE_P at tm+3.
- RST asserted in AVG_M → next cycle AVG_RST=1, PERT_SIGN=0, BUSY=0, J_PLUS=0, no DJ_VALID.
- With SPGD_METRIC_TIMEOUT_EN, TIMEOUT_CYCLES=16, AVG_DONE never asserted → ERR pulses once at the 16th AVG_P cycle, IDLE next cycle, DJ_OUT unchanged.

Source files
------------

// File: rtl/spgd_metric_diff.sv
// Two-sided SPGD metric sequencer: captures J+ and J- from the averager, emits dJ.
// Optional averager timeout is compiled in with SPGD_METRIC_TIMEOUT_EN.
module spgd_metric_diff #(
  parameter int unsigned ADC_WIDTH      = 12,
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        AVG_DONE,
  input  logic signed [ADC_WIDTH:0]   AVG_DATA,
  output logic                        AVG_RST,
  output logic                        PERT_SIGN,
  output logic                        BUSY,
  output logic signed [ADC_WIDTH:0]   J_PLUS,
  output logic signed [ADC_WIDTH:0]   J_MINUS,
  output logic signed [ADC_WIDTH+1:0] DJ_OUT,
  output logic                        DJ_VALID,
  output logic                        ERR
);

  localparam int unsigned MW = ADC_WIDTH + 1;
  localparam int unsigned DW = ADC_WIDTH + 2;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE_P,
    S_AVG_P,
    S_SETTLE_M,
    S_AVG_M,
    S_OUTPUT
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     settle_q, settle_d;
  logic [TW-1:0]   avg_q, avg_d;
  logic [MW-1:0]   jp_q, jp_d;
  logic [MW-1:0]   jm_q, jm_d;
  logic [DW-1:0]   dj_q, dj_d;
  logic            avg_rst_q;
  logic            pert_q;
  logic            busy_q;
  logic            djv_q;
  logic            in_avg;
  logic            cap;
  logic            tmo;
  logic [TW-1:0]   avg_inc;

  // Counter value zero marks the first AVG cycle, where AVG_DONE may be stale.
  assign in_avg = (state_q == S_AVG_P) || (state_q == S_AVG_M);
  assign cap    = in_avg && (avg_q != '0) && AVG_DONE;

`ifdef SPGD_METRIC_TIMEOUT_EN
  assign avg_inc = avg_q + TW'(1);
`else
  assign avg_inc = TW'(1);
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    avg_d    = avg_q;
    jp_d     = jp_q;
    jm_d     = jm_q;
    dj_d     = dj_q;
    tmo      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d  = S_SETTLE_P;
          settle_d = '0;
        end
      end
      S_SETTLE_P: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_AVG_P;
          avg_d   = '0;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      S_AVG_P: begin
        if (cap) begin
          jp_d     = AVG_DATA;
          state_d  = S_SETTLE_M;
          settle_d = '0;
        end else begin
          avg_d = avg_inc;
        end
      end
      S_SETTLE_M: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_AVG_M;
          avg_d   = '0;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      S_AVG_M: begin
        if (cap) begin
          jm_d    = AVG_DATA;
          dj_d    = {jp_q[MW-1], jp_q} - {AVG_DATA[MW-1], AVG_DATA};
          state_d = S_OUTPUT;
        end else begin
          avg_d = avg_inc;
        end
      end
      S_OUTPUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef SPGD_METRIC_TIMEOUT_EN
    if (in_avg && !cap && (avg_q == TMO_LAST)) begin
      tmo     = 1'b1;
      state_d = S_IDLE;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      avg_q     <= '0;
      jp_q      <= '0;
      jm_q      <= '0;
      dj_q      <= '0;
      avg_rst_q <= 1'b1;
      pert_q    <= 1'b0;
      busy_q    <= 1'b0;
      djv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      avg_q     <= avg_d;
      jp_q      <= jp_d;
      jm_q      <= jm_d;
      dj_q      <= dj_d;
      avg_rst_q <= !((state_d == S_AVG_P) || (state_d == S_AVG_M));
      pert_q    <= (state_d == S_SETTLE_M) || (state_d == S_AVG_M);
      busy_q    <= (state_d != S_IDLE);
      djv_q     <= (state_d == S_OUTPUT);
    end
  end

  assign AVG_RST   = avg_rst_q;
  assign PERT_SIGN = pert_q;
  assign BUSY      = busy_q;
  assign J_PLUS    = jp_q;
  assign J_MINUS   = jm_q;
  assign DJ_OUT    = dj_q;
  assign DJ_VALID  = djv_q;
  assign ERR       = tmo;

endmodule
